decoder4to16_pipe: RTL and testbench

//   Registered 4-to-16 binary-to-one-hot decoder with valid/ready handshakes on both sides.
//   It is the inverse of the 16-to-4 encoder: code k (0..15) produces a 16-bit word with only bit k active.
//   A 2-entry skid buffer decouples upstream from downstream back-pressure.

---
 rtl/decoder4to16_pipe.sv | 98 +++++++++
 tb/tb_decoder4to16_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder4to16_pipe.sv
// Registered 4-to-16 binary-to-one-hot decoder with valid/ready on both sides.
// A head register drives the output and a skid register absorbs one extra code.
module decoder4to16_pipe #(
   parameter bit OUT_ACTIVE_LOW = 1'b0,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_code,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          out_data,
   output logic [CNT_WIDTH-1:0] dec_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      state;
   logic [15:0] head;
   logic [15:0] skid;
   logic [15:0] code_dec;
   logic        accept;
   logic        pop;

   // Decoding happens at accept time; the registers always hold active-high one-hot words.
   assign code_dec  = 16'h0001 << in_code;

   assign in_ready  = (state != FULL) && !rst;
   assign out_valid = (state != EMPTY);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = OUT_ACTIVE_LOW ? ~head : head;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: head/skid are data registers but must be reset, since an idle head defines the idle output.
         state     <= EMPTY;
         head      <= '0;
         skid      <= '0;
         dec_count <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  head  <= code_dec;
                  state <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  head <= code_dec;
               end else if (accept) begin
                  skid  <= code_dec;
                  state <= FULL;
               end else if (pop) begin
                  head  <= '0;
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head  <= skid;
                  skid  <= '0;
                  state <= ONE;
               end
            end
            default: begin
               state <= EMPTY;
               head  <= '0;
               skid  <= '0;
            end
         endcase

         if (pop && (dec_count != {CNT_WIDTH{1'b1}}))
            dec_count <= dec_count + CNT_WIDTH'(1);
      end
   end

   a_onehot_when_valid : assert property (@(posedge clk) disable iff (rst)
      out_valid |-> $onehot(head));

   a_idle_inactive : assert property (@(posedge clk) disable iff (rst)
      !out_valid |-> (head == 16'h0000));

   a_stable_when_stalled : assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> $stable(out_data));

   a_no_ready_when_full : assert property (@(posedge clk)
      (state == FULL) |-> !in_ready);

endmodule

// File: tb/tb_decoder4to16_pipe.sv
// Bench for decoder4to16_pipe: three instances (default, active-low output, 4-bit counter)
// share stimulus and are compared every cycle against a queue-based model.
module tb_decoder4to16_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [3:0]  in_code;
   logic        out_ready;

   logic        in_ready,  in_ready_al,  in_ready_c4;
   logic        out_valid, out_valid_al, out_valid_c4;
   logic [15:0] out_data,  out_data_al,  out_data_c4;
   logic [15:0] dec_count, dec_count_al;
   logic [3:0]  dec_count_c4;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: FIFO of accepted codes (capacity 2) and a pop counter.
   int          q[$];
   int unsigned pops;

   always #5 clk = ~clk;

   decoder4to16_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .dec_count(dec_count)
   );

   decoder4to16_pipe #(.OUT_ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_al), .in_code(in_code),
      .out_valid(out_valid_al), .out_ready(out_ready), .out_data(out_data_al), .dec_count(dec_count_al)
   );

   decoder4to16_pipe #(.CNT_WIDTH(4)) dut_c4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c4), .in_code(in_code),
      .out_valid(out_valid_c4), .out_ready(out_ready), .out_data(out_data_c4), .dec_count(dec_count_c4)
   );

   // One clock of stimulus, model update and full comparison of all three instances.
   task automatic cycle(input logic r, input logic v, input logic [3:0] c, input logic ordy);
      logic        acc, pp, ev, er;
      logic [15:0] ed;
      logic [3:0]  ec4;
      int          ones;
      rst       = r;
      in_valid  = v;
      in_code   = c;
      out_ready = ordy;
      acc = v && !r && (q.size() < 2);
      pp  = ordy && (q.size() > 0);
      @(posedge clk);
      if (r) begin
         q.delete();
         pops = 0;
      end else begin
         if (pp) begin
            void'(q.pop_front());
            pops++;
         end
         if (acc) q.push_back(int'(c));
      end
      #1;
      ev  = (q.size() > 0);
      ed  = ev ? (16'h0001 << q[0]) : 16'h0000;
      er  = (q.size() < 2) && !r;
      ec4 = (pops > 15) ? 4'hF : 4'(pops);

      n_cmp++;
      if (out_valid !== ev) begin
         n_err++; $display("FAIL out_valid: got %b expected %b", out_valid, ev);
      end
      n_cmp++;
      if (out_data !== ed) begin
         n_err++; $display("FAIL out_data: got %h expected %h", out_data, ed);
      end
      n_cmp++;
      if (in_ready !== er) begin
         n_err++; $display("FAIL in_ready: got %b expected %b", in_ready, er);
      end
      n_cmp++;
      if (dec_count !== 16'(pops)) begin
         n_err++; $display("FAIL dec_count: got %0d expected %0d", dec_count, pops);
      end
      n_cmp++;
      if ((out_data_al !== ~ed) || (out_valid_al !== ev) || (in_ready_al !== er)) begin
         n_err++; $display("FAIL active_low: got data %h valid %b ready %b expected %h %b %b",
                           out_data_al, out_valid_al, in_ready_al, ~ed, ev, er);
      end
      n_cmp++;
      if ((dec_count_c4 !== ec4) || (out_data_c4 !== ed) || (out_valid_c4 !== ev)) begin
         n_err++; $display("FAIL cnt4: got count %h data %h valid %b expected %h %h %b",
                           dec_count_c4, out_data_c4, out_valid_c4, ec4, ed, ev);
      end
      if (out_valid === 1'b1) begin
         ones = $countones(out_data);
         n_cmp++;
         if (ones != 1) begin
            n_err++; $display("FAIL onehot: got %0d active bits expected 1 (data %h)", ones, out_data);
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 4'd0, 1'b1);
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 4'd0, 1'b0);
      cycle(1'b1, 1'b1, 4'd6, 1'b1);
      n_cmp++;
      if ((out_valid !== 1'b0) || (out_data !== 16'h0000) || (dec_count !== 16'd0) || (in_ready !== 1'b0)) begin
         n_err++; $display("FAIL reset_state: got v=%b d=%h cnt=%0d rdy=%b expected 0 0000 0 0",
                           out_valid, out_data, dec_count, in_ready);
      end
      n_cmp++;
      if (out_data_al !== 16'hFFFF) begin
         n_err++; $display("FAIL reset_idle_al: got %h expected ffff", out_data_al);
      end
      cycle(1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic test_sweep();
      logic [15:0] exp_word;
      for (int k = 0; k < 16; k++) begin
         cycle(1'b0, 1'b1, 4'(k), 1'b1);
         exp_word = 16'h0001 << k;
         n_cmp++;
         if (out_data !== exp_word) begin
            n_err++; $display("FAIL sweep_code%0d: got %h expected %h", k, out_data, exp_word);
         end
         if (k == 0) begin
            n_cmp++;
            if (out_data_al !== 16'hFFFE) begin
               n_err++; $display("FAIL active_low_code0: got %h expected fffe", out_data_al);
            end
         end
      end
      cycle(1'b0, 1'b0, 4'd0, 1'b1);
      n_cmp++;
      if ((dec_count !== 16'd16) || (out_data_al !== 16'hFFFF)) begin
         n_err++; $display("FAIL sweep_end: got count %0d idle_al %h expected 16 ffff", dec_count, out_data_al);
      end
   endtask

   task automatic test_backpressure();
      cycle(1'b0, 1'b1, 4'd3, 1'b0);
      cycle(1'b0, 1'b1, 4'd7, 1'b0);
      n_cmp++;
      if ((in_ready !== 1'b0) || (out_data !== 16'h0008)) begin
         n_err++; $display("FAIL bp_full: got rdy=%b data=%h expected 0 0008", in_ready, out_data);
      end
      cycle(1'b0, 1'b1, 4'd9, 1'b0);
      n_cmp++;
      if (out_data !== 16'h0008) begin
         n_err++; $display("FAIL bp_hold: got %h expected 0008", out_data);
      end
      cycle(1'b0, 1'b1, 4'd9, 1'b1);
      n_cmp++;
      if (out_data !== 16'h0080) begin
         n_err++; $display("FAIL bp_second: got %h expected 0080", out_data);
      end
      cycle(1'b0, 1'b1, 4'd9, 1'b1);
      n_cmp++;
      if (out_data !== 16'h0200) begin
         n_err++; $display("FAIL bp_third: got %h expected 0200", out_data);
      end
      drain();
   endtask

   task automatic test_simultaneous();
      cycle(1'b0, 1'b1, 4'd5, 1'b0);
      n_cmp++;
      if (out_data !== 16'h0020) begin
         n_err++; $display("FAIL sim_first: got %h expected 0020", out_data);
      end
      cycle(1'b0, 1'b1, 4'd12, 1'b1);
      n_cmp++;
      if ((out_data !== 16'h1000) || (out_valid !== 1'b1) || (in_ready !== 1'b1)) begin
         n_err++; $display("FAIL sim_no_bubble: got data=%h v=%b rdy=%b expected 1000 1 1",
                           out_data, out_valid, in_ready);
      end
      drain();
   endtask

   task automatic test_reset_full();
      cycle(1'b0, 1'b1, 4'd1, 1'b0);
      cycle(1'b0, 1'b1, 4'd2, 1'b0);
      cycle(1'b1, 1'b1, 4'd4, 1'b1);
      n_cmp++;
      if ((out_valid !== 1'b0) || (out_data !== 16'h0000) || (dec_count !== 16'd0) || (in_ready !== 1'b0)) begin
         n_err++; $display("FAIL reset_full: got v=%b d=%h cnt=%0d rdy=%b expected 0 0000 0 0",
                           out_valid, out_data, dec_count, in_ready);
      end
      cycle(1'b0, 1'b0, 4'd0, 1'b0);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_release: got rdy=%b expected 1", in_ready);
      end
   endtask

   task automatic test_saturation();
      cycle(1'b1, 1'b0, 4'd0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 4'(i), 1'b1);
      drain();
      n_cmp++;
      if ((dec_count_c4 !== 4'hF) || (dec_count !== 16'd20)) begin
         n_err++; $display("FAIL saturate: got c4=%h c16=%0d expected f 20", dec_count_c4, dec_count);
      end
   endtask

   task automatic test_random();
      logic r, v, o;
      logic [3:0] c;
      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 49) == 0);
         v = ($urandom_range(0, 3) != 0);
         o = ($urandom_range(0, 2) != 0);
         c = 4'($urandom_range(0, 15));
         cycle(r, v, c, o);
      end
      drain();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_code   = 4'd0;
      out_ready = 1'b0;
      pops      = 0;
      test_reset();
      test_sweep();
      test_backpressure();
      test_simultaneous();
      test_reset_full();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
